// File: rtl/divider_pkg.sv
// Shared definitions for the shift-subtract divider: state encoding and default width.
package divider_pkg;

    localparam int N_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CHK  = 2'b01,
        DIV  = 2'b10,
        DONE = 2'b11
    } state_t;

endpackage

// File: rtl/divider_control.sv
// Divider sequencer: IDLE -> CHK -> DIV x N -> DONE, with the step counter.
module divider_control
    import divider_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic Clk,
    input  logic Reset,
    input  logic St,
    input  logic Ovf,
    output logic Load,
    output logic Sh,
    output logic Su,
    output logic Fin,
    output logic Idle,
    output logic Done
);

    localparam int CW = $clog2(N + 1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            last;

    assign last = (cnt == CW'(N - 1));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (St) begin
                    state <= CHK;
                    cnt   <= '0;
                end
                CHK:  state <= Ovf ? DONE : DIV;
                DIV: begin
                    cnt <= cnt + 1'b1;
                    if (last) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Moore status outputs; Load is the only strobe that looks at St.
    assign Idle = (state == IDLE);
    assign Done = (state == DONE);
    assign Load = Idle & St;
    assign Sh   = (state == DIV);
    assign Su   = (state == CHK) & Ovf;
    assign Fin  = Sh & last;

endmodule

// File: rtl/shift_sub_divider.sv
// Restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
module shift_sub_divider
    import divider_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             St,
    input  logic [2*N-1:0]   Dividend,
    input  logic [N-1:0]     Divisor,
    output logic [N-1:0]     Quotient,
    output logic [N-1:0]     Remainder,
    output logic             V,
    output logic             Idle,
    output logic             Done
);

    logic [2*N:0]  acc;
    logic [N-1:0]  dvs;
    logic [2*N:0]  t_sh;
    logic [2*N:0]  t_next;
    logic [N:0]    hi;
    logic [N:0]    hi_sub;
    logic          ge;
    logic          ovf;
    logic          load, sh, su, fin;

    // Quotient fits in N bits only if the upper dividend half is below the divisor.
    assign ovf    = (dvs == '0) || (acc[2*N-1:N] >= dvs);

    assign t_sh   = acc << 1;
    assign hi     = t_sh[2*N:N];
    assign ge     = hi >= {1'b0, dvs};
    assign hi_sub = hi - {1'b0, dvs};
    assign t_next = ge ? {hi_sub, t_sh[N-1:1], 1'b1} : t_sh;

    divider_control #(.N(N)) u_ctrl (
        .Clk   (Clk),
        .Reset (Reset),
        .St    (St),
        .Ovf   (ovf),
        .Load  (load),
        .Sh    (sh),
        .Su    (su),
        .Fin   (fin),
        .Idle  (Idle),
        .Done  (Done)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            acc       <= '0;
            dvs       <= '0;
            Quotient  <= '0;
            Remainder <= '0;
            V         <= 1'b0;
        end else begin
            if (load) begin
                acc <= {1'b0, Dividend};
                dvs <= Divisor;
                V   <= 1'b0;
            end
            if (su) begin
                V         <= 1'b1;
                Quotient  <= '0;
                Remainder <= '0;
            end
            if (sh) begin
                acc <= t_next;
                if (fin) begin
                    Quotient  <= t_next[N-1:0];
                    Remainder <= t_next[2*N-1:N];
                end
            end
        end
    end

endmodule
